keypad_scan_ctrl: RTL
=====================

# keypad_scan_ctrl

Scan scheduler for the 4x4 matrix keypad. Sequences a 2-bit column index through the four columns, freezes it when a key is detected, debounces the press, and delivers one 4-bit key code per press over a valid/ready handshake. Sits between the keypad pins and the input-decode logic; the frozen column index doubles as a hold/advance control for the scan counter.

## Interface
- SCAN_DIV, 1000: clock cycles each column is driven before its rows are sampled (≥2).
- DB_CYCLES, 50000: consecutive stable cycles required to accept a press or a release (≥2).
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- row_i  in  4  raw keypad rows, active-high, asynchronous to clk.
- col_o  out  4  one-hot column drive, active-high.
- scan_idx_o  out  2  current column index (col_o = 1 << scan_idx_o).
- key_o  out  4  key code {row_idx[1:0], col_idx[1:0]}.
- key_valid_o  out  1  key_o holds an unconsumed code.
- key_ready_i  in  1  consumer accepts key_o when high together with key_valid_o.

## Operation
- row_i passes through a 2-FF synchronizer; all decisions use the synchronized value rows_s.
- States: SCAN, PRESS_DB, PRESENT, RELEASE_DB.
- SCAN: dwell counter counts 0..SCAN_DIV-1. At terminal count: rows_s ≠ 0 → latch rows_s into row_lat, clear counter, go PRESS_DB, column frozen; rows_s = 0 → scan_idx_o += 1 (3 wraps to 0), clear counter.
- PRESS_DB: column frozen. rows_s ≠ row_lat any cycle → SCAN, same column, dwell restarts. Counter reaches DB_CYCLES-1 with rows_s = row_lat → key_o = {lowest set row index of row_lat, scan_idx_o}, key_valid_o = 1, go PRESENT.
- Multiple rows set: lowest row index wins; the others are ignored for this press.
- PRESENT: key_valid_o and key_o held stable until key_valid_o && key_ready_i; then key_valid_o = 0 next cycle, go RELEASE_DB. Release of the key before acceptance does not drop or change the code.
- RELEASE_DB: counter increments while rows_s = 0, clears on any rows_s ≠ 0. Reaching DB_CYCLES-1 → scan_idx_o advances by 1, go SCAN with dwell cleared.
- One code per physical press; holding a key never repeats it.
- No buffering: scanning is halted while a code is pending.

## Timing
- Reset values: col_o = 4'b0001, scan_idx_o = 0, key_o = 0, key_valid_o = 0, state SCAN, all counters 0, synchronizer flops 0.
- rst has priority over every transition, including mid-debounce and mid-handshake; a pending code is discarded.
- Column period in SCAN = SCAN_DIV cycles; full sweep = 4·SCAN_DIV.
- Synchronizer latency: 2 cycles from row_i to rows_s.
- Press latency: key_valid_o rises DB_CYCLES cycles after the SCAN terminal-count sample that detected the press, given stable rows.
- key_ready_i high in the cycle key_valid_o rises counts as an immediate transfer (one-cycle valid pulse).
- col_o and scan_idx_o change only on the cycle the index advances; never mid-dwell.

## Structure
- Shared package keypad_pkg: state enum typedef, KEY_W = 4, COLS = 4, ROWS = 4, and a row_priority_enc function (4-bit one-hot/multi → 2-bit lowest index).
- One sub-module, keypad_debounce_cnt: width derived from max(SCAN_DIV, DB_CYCLES), with clear/enable inputs and a terminal-count output. It serves both the dwell counter and the debounce counter, selected by state.

## Test plan
All with SCAN_DIV = 4, DB_CYCLES = 8.
- Reset then idle rows: col_o cycles 0001→0010→0100→1000→0001 every 4 cycles; key_valid_o stays 0.
- Press row 2 while col 1 is driven, stable, key_ready_i = 1: key_o = 4'b1001, one-cycle key_valid_o; no repeat while held; scan resumes at col 2 8 cycles after release.
- Bounce: rows toggle 0100/0000 every 3 cycles during PRESS_DB: no key_valid_o; the same column restarts its dwell.
- Back-pressure: key_ready_i = 0 for 20 cycles, key released after 5: key_valid_o and key_o stay constant; transfer occurs on the first ready cycle; release debounce then completes.
- Rows 1 and 3 pressed together on col 0: key_o = 4'b0100.
- rst asserted in PRESENT: next cycle key_valid_o = 0, col_o = 0001, key_o = 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, sizes and helpers for the 4x4 keypad scan controller.
package keypad_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned ROWS  = 4;

  typedef enum logic [1:0] {
    StScan,
    StPressDb,
    StPresent,
    StReleaseDb
  } state_e;

  // Lowest set row wins when several rows are active at once.
  function automatic logic [1:0] row_priority_enc(input logic [ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (rows[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce_cnt.sv
// Clearable up-counter with a programmable terminal count; shared by the
// column dwell timer and the press/release debounce timer.
module keypad_debounce_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] last_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == last_i);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column scan scheduler for a 4x4 keypad: scans, debounces a press, hands one
// code per press over valid/ready, then debounces the release before resuming.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROWS-1:0]  row_i,
  output logic [COLS-1:0]  col_o,
  output logic [1:0]       scan_idx_o,
  output logic [KEY_W-1:0] key_o,
  output logic             key_valid_o,
  input  logic             key_ready_i
);

  localparam int unsigned CntMax = (SCAN_DIV > DB_CYCLES) ? SCAN_DIV : DB_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] DbLast   = CntW'(DB_CYCLES - 1);

  logic [ROWS-1:0]  row_meta_q, rows_s_q;
  state_e           state_q, state_d;
  logic [1:0]       scan_idx_q, scan_idx_d;
  logic [ROWS-1:0]  row_lat_q, row_lat_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;

  logic            cnt_clr, cnt_en, cnt_tc;
  logic [CntW-1:0] cnt_last;

  keypad_debounce_cnt #(
    .Width(CntW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .last_i(cnt_last),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    scan_idx_d  = scan_idx_q;
    row_lat_d   = row_lat_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    cnt_last    = (state_q == StScan) ? ScanLast : DbLast;

    unique case (state_q)
      StScan: begin
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          if (rows_s_q != '0) begin
            row_lat_d = rows_s_q;
            state_d   = StPressDb;
          end else begin
            scan_idx_d = scan_idx_q + 2'd1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      StPressDb: begin
        // Any change from the latched pattern is a bounce: retry this column.
        if (rows_s_q != row_lat_q) begin
          state_d = StScan;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          key_d       = {row_priority_enc(row_lat_q), scan_idx_q};
          key_valid_d = 1'b1;
          state_d     = StPresent;
          cnt_clr     = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StPresent: begin
        if (key_ready_i) begin
          key_valid_d = 1'b0;
          state_d     = StReleaseDb;
          cnt_clr     = 1'b1;
        end
      end
      StReleaseDb: begin
        if (rows_s_q != '0) begin
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          scan_idx_d = scan_idx_q + 2'd1;
          state_d    = StScan;
          cnt_clr    = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q  <= '0;
      rows_s_q    <= '0;
      state_q     <= StScan;
      scan_idx_q  <= 2'd0;
      row_lat_q   <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      row_meta_q  <= row_i;
      rows_s_q    <= row_meta_q;
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      row_lat_q   <= row_lat_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign col_o       = 4'b0001 << scan_idx_q;
  assign scan_idx_o  = scan_idx_q;
  assign key_o       = key_q;
  assign key_valid_o = key_valid_q;

endmodule
